// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, inverse S-box ROM, GF(2^8) arithmetic and byte-index helpers
package aes_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t [15:0] aes_state_t;

  typedef enum logic [2:0] {IDLE, MIX, SHIFT, SUB, DONE} fsm_t;

  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic byte_t xtime(byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(byte_t a, byte_t b);
    byte_t p = '0;
    byte_t x = a;
    for (int i = 0; i < 8; i++) begin
      p = b[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction

  // AES byte 4c+r lives in element 15-(4c+r) of the packed state, so byte 0 is the MSB
  function automatic logic [3:0] slot(int r, int c);
    return 4'(15 - 4 * c - r);
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// aes_inv_mix_column: combinational InvMixColumns on one 32-bit column (row 0 in the MSB byte)
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  // Each output row is the circulant {0e,0b,0d,09} product starting at its own row
  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++)
      col_o[31-8*r -: 8] = gf_mul(8'h0e, col_i[31-8*r -: 8])
                         ^ gf_mul(8'h0b, col_i[31-8*((r+1)%4) -: 8])
                         ^ gf_mul(8'h0d, col_i[31-8*((r+2)%4) -: 8])
                         ^ gf_mul(8'h09, col_i[31-8*((r+3)%4) -: 8]);
  end

endmodule

// File: rtl/aes_one_round_decrypt.sv
// aes_one_round_decrypt: multi-cycle inverse of one AES-128 round, one inverse step per clock
module aes_one_round_decrypt
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic [127:0] plaintext,
  output logic         done
);

  fsm_t       fsm_q;
  aes_state_t st_q;
  aes_state_t mix_st;
  aes_state_t shr_st;
  aes_state_t sub_st;
  logic [127:0] pt_q;
  logic         done_q;

  genvar c, r, i;

  for (c = 0; c < 4; c++) begin : g_mix
    aes_inv_mix_column u_col (
      .col_i(st_q[15-4*c -: 4]),
      .col_o(mix_st[15-4*c -: 4])
    );
  end

  for (r = 0; r < 4; r++) begin : g_row
    for (c = 0; c < 4; c++) begin : g_col
      assign shr_st[slot(r, c)] = st_q[slot(r, (c + 4 - r) % 4)];
    end
  end

  for (i = 0; i < 16; i++) begin : g_sub
    assign sub_st[i] = INV_SBOX[st_q[i]];
  end

  // Control FSM and datapath registers; each state applies one inverse step to st_q
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q  <= IDLE;
      st_q   <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      case (fsm_q)
        IDLE, DONE: if (start) begin
          st_q   <= ciphertext ^ key;
          done_q <= 1'b0;
          fsm_q  <= MIX;
        end
        MIX: begin
          st_q  <= mix_st;
          fsm_q <= SHIFT;
        end
        SHIFT: begin
          st_q  <= shr_st;
          fsm_q <= SUB;
        end
        SUB: begin
          pt_q   <= sub_st;
          done_q <= 1'b1;
          fsm_q  <= DONE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign plaintext = pt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_one_round_decrypt.sv
// tb_aes_one_round_decrypt: directed and random checks against a GF(2^8) reference of one inverse round
module tb_aes_one_round_decrypt;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic [127:0] plaintext;
  logic         done;

  int nvec = 0;
  int nerr = 0;
  logic [7:0] isb [256];

  localparam logic [127:0] NOM_CT  = 128'h08938A533D49A4F5DD8C42A3717876DA;
  localparam logic [127:0] NOM_KEY = 128'h12345678987654321234567898765432;
  localparam logic [127:0] NOM_PT  = 128'hABCDEF01020304050607080900000000;

  aes_one_round_decrypt dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ciphertext(ciphertext),
    .key(key),
    .plaintext(plaintext),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    int p = 0;
    int x = a;
    for (int k = 0; k < 8; k++) begin
      if (((b >> k) & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    logic [15:0] w = {v, v} << n;
    return w[15:8];
  endfunction

  // Inverse S-box derived from the forward S-box definition: affine(x^254), then inverted
  function automatic void build_isb();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'd1;
      logic [7:0] s;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'd0;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isb[s] = 8'(x);
    end
  endfunction

  function automatic logic [127:0] model(logic [127:0] ct, logic [127:0] k);
    logic [127:0] x = ct ^ k;
    logic [127:0] o = '0;
    logic [7:0] s [4][4];
    logic [7:0] m [4][4];
    logic [7:0] t [4][4];
    logic [7:0] coef [4];
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) s[r][c] = x[127-8*(4*c+r) -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        m[r][c] = 8'h00;
        for (int j = 0; j < 4; j++) m[r][c] = m[r][c] ^ gmul(coef[j], s[(r+j)%4][c]);
      end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[r][(c+r)%4] = m[r][c];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[127-8*(4*c+r) -: 8] = isb[t[r][c]];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a start, scramble the inputs, then check the done profile and the result
  task automatic run(input string tag, input logic [127:0] ct, input logic [127:0] k, input logic [127:0] exp);
    start = 1'b1;
    ciphertext = ct;
    key = k;
    step();
    start = 1'b0;
    ciphertext = rnd128();
    key = rnd128();
    chk({tag, "_done_n1"}, {127'd0, done}, 128'd0);
    step();
    chk({tag, "_done_n2"}, {127'd0, done}, 128'd0);
    step();
    chk({tag, "_done_n3"}, {127'd0, done}, 128'd0);
    step();
    chk({tag, "_done"}, {127'd0, done}, 128'd1);
    chk({tag, "_pt"}, plaintext, exp);
  endtask

  initial begin
    logic [127:0] ct, k;
    build_isb();
    start = 1'b1;
    ciphertext = rnd128();
    key = rnd128();
    repeat (4) step();
    chk("reset_done", {127'd0, done}, 128'd0);
    chk("reset_pt", plaintext, 128'd0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    chk("idle_done", {127'd0, done}, 128'd0);

    run("nominal", NOM_CT, NOM_KEY, NOM_PT);
    chk("nominal_model", plaintext, model(NOM_CT, NOM_KEY));
    for (int n = 0; n < 3; n++) begin
      step();
      chk("hold_done", {127'd0, done}, 128'd1);
      chk("hold_pt", plaintext, NOM_PT);
    end

    run("zero", NOM_KEY, NOM_KEY, {16{8'h52}});
    run("const", {16{8'h63}}, 128'd0, 128'd0);

    start = 1'b1;
    ciphertext = NOM_CT;
    key = NOM_KEY;
    step();
    ciphertext = rnd128();
    key = rnd128();
    step();
    start = 1'b0;
    step();
    chk("busy_done_n2", {127'd0, done}, 128'd0);
    step();
    chk("busy_done", {127'd0, done}, 128'd1);
    chk("busy_pt", plaintext, NOM_PT);

    start = 1'b1;
    ciphertext = {16{8'h63}};
    key = 128'd0;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_done", {127'd0, done}, 128'd0);
    chk("midrst_pt", plaintext, 128'd0);
    rst_n = 1'b1;
    step();
    step();
    chk("midrst_noresume_done", {127'd0, done}, 128'd0);
    step();
    chk("midrst_noresume_pt", plaintext, 128'd0);
    run("after_rst", NOM_CT, NOM_KEY, NOM_PT);

    for (int n = 0; n < 16; n++) begin
      ct = rnd128();
      k = (n == 3) ? 128'd0 : rnd128();
      run("b2b_rand", ct, k, model(ct, k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
